// File: rtl/pipeline_pkg.sv
// pipeline_pkg: constants and types shared by the fetch pipeline.
//   XLEN     - datapath width
//   NOP      - instruction placed in IF/ID when it is cleared (addi x0,x0,0)
//   PC_INC   - PC step between sequential instructions
//   fetch_state_e - fetch FSM states; SKID exists only when FETCH_SKID_EN is defined
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

`ifdef FETCH_SKID_EN
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SKID,
    DROP
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;
`endif

  // Sequential successor of a PC; the adder wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_plus_inc(input logic [XLEN-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   load              - capture instr_in/pc_in and mark the entry valid
//   hold              - keep current contents (stall)
//   clear             - replace instruction with NOP and drop valid; pc_id kept
//   instr_in, pc_in   - incoming instruction word and its PC
//   instruction, pc_id, valid_id - registered IF/ID contents
// Priority is clear > hold > load.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            hold,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc_id,
  output logic            valid_id
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= NOP;
      pc_id       <= '0;
      valid_id    <= 1'b0;
    end else if (clear) begin
      instruction <= NOP;
      valid_id    <= 1'b0;
    end else if (hold) begin
      instruction <= instruction;
      pc_id       <= pc_id;
      valid_id    <= valid_id;
    end else if (load) begin
      instruction <= instr_in;
      pc_id       <= pc_in;
      valid_id    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single outstanding memory request.
// Parameter:
//   RESET_PC     - PC loaded on reset
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   SignalPC     - stall from hazard unit (1 = hold PC and IF/ID)
//   Flush        - taken branch/jump from EX; redirects PC to BranchTarget
//   BranchTarget - redirect address
//   imem_req     - one-cycle fetch request, address on imem_addr (= PC)
//   imem_valid   - response strobe, imem_rdata valid with it
//   Instruction, PC_ID, Valid_ID - IF/ID register contents
// Build option FETCH_SKID_EN: a response arriving during a stall is kept in a
// one-entry skid buffer (SKID state). Without it such a response is dropped
// and the same PC is re-requested once the stall clears.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            SignalPC,
  input  logic            Flush,
  input  logic [XLEN-1:0] BranchTarget,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] Instruction,
  output logic [XLEN-1:0] PC_ID,
  output logic            Valid_ID
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;

  logic            pc_redirect;
  logic            pc_advance;
  logic            ifid_load;
  logic            ifid_clear;
  logic [XLEN-1:0] ifid_instr;

`ifdef FETCH_SKID_EN
  logic [XLEN-1:0] skid_data;
  logic            skid_capture;
  logic            ifid_from_skid;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
`ifdef FETCH_SKID_EN
        if (!Flush) begin
          state_next = WAIT;
        end
`else
        if (!Flush && !SignalPC) begin
          state_next = WAIT;
        end
`endif
      end
      WAIT: begin
        if (Flush) begin
          state_next = imem_valid ? IDLE : DROP;
        end else if (imem_valid) begin
`ifdef FETCH_SKID_EN
          state_next = SignalPC ? SKID : IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef FETCH_SKID_EN
      SKID: begin
        if (Flush || !SignalPC) begin
          state_next = IDLE;
        end
      end
`endif
      DROP: begin
        // The response being dropped is the only one outstanding, so once it
        // arrives a new fetch may start even if a redirect lands that cycle.
        if (imem_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    imem_req    = 1'b0;
    pc_redirect = 1'b0;
    pc_advance  = 1'b0;
    ifid_load   = 1'b0;
    ifid_clear  = 1'b0;
`ifdef FETCH_SKID_EN
    skid_capture   = 1'b0;
    ifid_from_skid = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (Flush) begin
          pc_redirect = 1'b1;
          ifid_clear  = 1'b1;
        end else begin
          // Gated by rst_n so the request is low for the whole reset period.
`ifdef FETCH_SKID_EN
          imem_req = rst_n;
`else
          imem_req = rst_n && !SignalPC;
`endif
        end
      end
      WAIT: begin
        if (Flush) begin
          pc_redirect = 1'b1;
          ifid_clear  = 1'b1;
        end else if (imem_valid) begin
          if (!SignalPC) begin
            ifid_load  = 1'b1;
            pc_advance = 1'b1;
          end else begin
`ifdef FETCH_SKID_EN
            skid_capture = 1'b1;
`endif
          end
        end
      end
`ifdef FETCH_SKID_EN
      SKID: begin
        if (Flush) begin
          pc_redirect = 1'b1;
          ifid_clear  = 1'b1;
        end else if (!SignalPC) begin
          ifid_load      = 1'b1;
          ifid_from_skid = 1'b1;
          pc_advance     = 1'b1;
        end
      end
`endif
      DROP: begin
        if (Flush) begin
          pc_redirect = 1'b1;
          ifid_clear  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // PC register; SignalPC never reaches a load/advance path so PC holds on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pc_redirect) begin
      pc <= BranchTarget;
    end else if (pc_advance) begin
      pc <= pc_plus_inc(pc);
    end
  end

`ifdef FETCH_SKID_EN
  // Skid storage; SKID state itself marks the entry as occupied, so leaving
  // SKID (drain or flush) empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data <= '0;
    end else if (skid_capture) begin
      skid_data <= imem_rdata;
    end
  end

  assign ifid_instr = ifid_from_skid ? skid_data : imem_rdata;
`else
  assign ifid_instr = imem_rdata;
`endif

  assign imem_addr = pc;

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ifid_load),
    .hold        (SignalPC),
    .clear       (ifid_clear),
    .instr_in    (ifid_instr),
    .pc_in       (pc),
    .instruction (Instruction),
    .pc_id       (PC_ID),
    .valid_id    (Valid_ID)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a small
// instruction-memory responder of configurable latency.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        SignalPC;
  logic        Flush;
  logic [31:0] BranchTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PC_ID;
  logic        Valid_ID;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  int unsigned passed;
  int unsigned total;

  // memory responder state
  logic        pend;
  logic [31:0] pend_addr;
  int unsigned cnt;
  int unsigned lat;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SignalPC     (SignalPC),
    .Flush        (Flush),
    .BranchTarget (BranchTarget),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .Instruction  (Instruction),
    .PC_ID        (PC_ID),
    .Valid_ID     (Valid_ID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h8A62_0013;
      32'h0000_0008: return 32'h00B0_0113;
      32'h0000_000C: return 32'h0000_0033;
      32'h0000_0100: return 32'h0000_0113;
      32'hFFFF_FFFC: return 32'h0000_0193;
      default:       return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: samples the request, crosses one rising edge, drives
  // the memory response just after that edge, and returns at the next negedge.
  task automatic tick();
    if (imem_req && rst_n && !pend) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      cnt       = lat;
    end
    @(posedge clk);
    #1;
    if (pend) begin
      if (cnt <= 1) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(pend_addr);
        pend       = 1'b0;
      end else begin
        imem_valid = 1'b0;
        cnt--;
      end
    end else begin
      imem_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    pend         = 1'b0;
    pend_addr    = '0;
    cnt          = 0;
    lat          = 1;
    rst_n        = 1'b0;
    SignalPC     = 1'b0;
    Flush        = 1'b0;
    BranchTarget = '0;
    imem_valid   = 1'b0;
    imem_rdata   = '0;

    // reset values
    @(negedge clk);
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_instr", Instruction, NOP_W);
    check("rst_pcid",  PC_ID, 32'd0);
    check("rst_valid", {31'd0, Valid_ID}, 32'd0);
    check("rst_addr",  imem_addr, 32'd0);

    // first fetch after reset release
    rst_n = 1'b1;
    #1;
    check("first_req",  {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
    tick();
    check("wait_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("a_instr", Instruction, 32'h00A0_0093);
    check("a_pcid",  PC_ID, 32'd0);
    check("a_valid", {31'd0, Valid_ID}, 32'd1);
    check("a_addr",  imem_addr, 32'd4);
    check("a_req",   {31'd0, imem_req}, 32'd1);

    // stall for three cycles with 8A620013 in IF/ID
    tick();
    tick();
    check("b_instr", Instruction, 32'h8A62_0013);
    check("b_pcid",  PC_ID, 32'd4);
    check("b_addr",  imem_addr, 32'd8);
    SignalPC = 1'b1;
    #1;
`ifndef FETCH_SKID_EN
    check("b_req_stalled", {31'd0, imem_req}, 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_hold_instr", Instruction, 32'h8A62_0013);
      check("b_hold_pcid",  PC_ID, 32'd4);
      check("b_hold_valid", {31'd0, Valid_ID}, 32'd1);
      check("b_hold_addr",  imem_addr, 32'd8);
    end
    SignalPC = 1'b0;
    #1;
`ifdef FETCH_SKID_EN
    check("b_rel_req", {31'd0, imem_req}, 32'd0);
    tick();
`else
    check("b_rel_req",  {31'd0, imem_req}, 32'd1);
    check("b_rel_addr", imem_addr, 32'd8);
    tick();
    tick();
`endif
    check("b_res_instr", Instruction, 32'h00B0_0113);
    check("b_res_pcid",  PC_ID, 32'd8);
    check("b_res_addr",  imem_addr, 32'd12);

    // response 00000033 arrives while stalled
    tick();
    SignalPC = 1'b1;
    #1;
    tick();
    check("c_instr", Instruction, 32'h00B0_0113);
    check("c_pcid",  PC_ID, 32'd8);
    check("c_req",   {31'd0, imem_req}, 32'd0);
    check("c_addr",  imem_addr, 32'd12);
    SignalPC = 1'b0;
    #1;
`ifdef FETCH_SKID_EN
    check("c_rel_req", {31'd0, imem_req}, 32'd0);
    tick();
`else
    check("c_rel_req",  {31'd0, imem_req}, 32'd1);
    check("c_rel_addr", imem_addr, 32'd12);
    tick();
    tick();
`endif
    check("c_res_instr", Instruction, 32'h0000_0033);
    check("c_res_pcid",  PC_ID, 32'd12);
    check("c_res_addr",  imem_addr, 32'd16);

    // flush while a 2-cycle response is pending -> DROP
    lat = 2;
    tick();
    Flush        = 1'b1;
    BranchTarget = 32'h0000_0100;
    #1;
    tick();
    Flush = 1'b0;
    #1;
    check("d_instr", Instruction, NOP_W);
    check("d_valid", {31'd0, Valid_ID}, 32'd0);
    check("d_pcid",  PC_ID, 32'd12);
    check("d_req",   {31'd0, imem_req}, 32'd0);
    check("d_addr",  imem_addr, 32'h0000_0100);
    lat = 1;
    tick();
    check("d_req2",   {31'd0, imem_req}, 32'd1);
    check("d_addr2",  imem_addr, 32'h0000_0100);
    check("d_instr2", Instruction, NOP_W);
    tick();
    tick();
    check("d_res_instr", Instruction, 32'h0000_0113);
    check("d_res_pcid",  PC_ID, 32'h0000_0100);
    check("d_res_valid", {31'd0, Valid_ID}, 32'd1);
    check("d_res_addr",  imem_addr, 32'h0000_0104);

    // flush in IDLE to the last word, then wrap
    Flush        = 1'b1;
    BranchTarget = 32'hFFFF_FFFC;
    #1;
    check("e_req_flush", {31'd0, imem_req}, 32'd0);
    tick();
    Flush = 1'b0;
    #1;
    check("e_instr", Instruction, NOP_W);
    check("e_valid", {31'd0, Valid_ID}, 32'd0);
    check("e_pcid",  PC_ID, 32'h0000_0100);
    check("e_addr",  imem_addr, 32'hFFFF_FFFC);
    check("e_req",   {31'd0, imem_req}, 32'd1);
    tick();
    tick();
    check("e_res_instr", Instruction, 32'h0000_0193);
    check("e_res_pcid",  PC_ID, 32'hFFFF_FFFC);
    check("e_wrap_addr", imem_addr, 32'h0000_0000);

    // reset asserted during WAIT
    tick();
    tick();
    tick();
    check("f_pre_addr", imem_addr, 32'd4);
    rst_n      = 1'b0;
    pend       = 1'b0;
    imem_valid = 1'b0;
    #1;
    check("f_req",   {31'd0, imem_req}, 32'd0);
    check("f_instr", Instruction, NOP_W);
    check("f_pcid",  PC_ID, 32'd0);
    check("f_valid", {31'd0, Valid_ID}, 32'd0);
    check("f_addr",  imem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("f_rel_req",  {31'd0, imem_req}, 32'd1);
    check("f_rel_addr", imem_addr, 32'd0);
    tick();
    tick();
    check("f_res_instr", Instruction, 32'h00A0_0093);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port SignalPC  input  1  stall from hazard unit; 1 = hold PC and IF/ID.
REQ-005 SHALL have port Flush  input  1  branch/jump taken, from EX.
REQ-006 SHALL have port BranchTarget  input  32  redirect PC, sampled when Flush=1.
REQ-007 SHALL have port imem_req  output  1  one-cycle fetch request pulse.
REQ-008 SHALL have port imem_addr  output  32  fetch address, equals PC.
REQ-009 SHALL have port imem_valid  input  1  response strobe, at least 1 cycle after imem_req.
REQ-010 SHALL have port imem_rdata  input  32  fetched word, valid with imem_valid.
REQ-011 SHALL have port Instruction  output  32  IF/ID instruction, feeds decode and hazard unit.
REQ-012 SHALL have port PC_ID  output  32  PC of the instruction in IF/ID.
REQ-013 SHALL have port Valid_ID  output  1  IF/ID holds a real instruction.

Function
REQ-014 SHALL allow at most one imem request outstanding.
REQ-015 SHALL implement FSM states IDLE, WAIT, SKID, DROP.
REQ-016 IDLE: SHALL pulse imem_req=1 with imem_addr=PC and go to WAIT; Flush in IDLE loads PC=BranchTarget, clears IF/ID, no request that cycle.
REQ-017 WAIT, imem_valid=1, SignalPC=0, Flush=0: SHALL load IF/ID {imem_rdata, PC, Valid_ID=1}, PC<=PC+4 (mod 2^32), go to IDLE.
REQ-018 WAIT, imem_valid=1, SignalPC=1, Flush=0: behaviour per FETCH_SKID_EN (REQ-026/027).
REQ-019 WAIT, Flush=1: SHALL load PC=BranchTarget and clear IF/ID; if imem_valid=1 same cycle, discard data and go to IDLE, else go to DROP.
REQ-020 DROP: SHALL discard the next imem_valid response and go to IDLE; Flush in DROP updates PC and stays in DROP.
REQ-021 SKID: when SignalPC=0 SHALL load IF/ID from skid buffer, PC<=PC+4, go to IDLE; Flush has priority: clear skid and IF/ID, load PC=BranchTarget, go to IDLE.
REQ-022 Priority on IF/ID SHALL be Flush > SignalPC > load; clear means Instruction=32'h00000013 (NOP), Valid_ID=0, PC_ID unchanged.
REQ-023 While SignalPC=1 and Flush=0, Instruction, PC_ID, Valid_ID and PC SHALL hold.
REQ-024 Steady-state throughput SHALL be one instruction per two cycles with single-cycle memory latency.

Reset
REQ-025 On rst_n=0 SHALL immediately set PC=RESET_PC, state IDLE, imem_req=0, Instruction=32'h00000013, PC_ID=0, Valid_ID=0, skid empty; first imem_req in the first clk edge after rst_n=1; reset mid-request discards any later response.

Configuration
REQ-026 With FETCH_SKID_EN defined: response arriving with SignalPC=1 SHALL be captured in a one-entry skid buffer, state SKID, PC unchanged.
REQ-027 Without FETCH_SKID_EN: that response SHALL be discarded, PC unchanged, go to IDLE; IDLE SHALL NOT issue imem_req while SignalPC=1; no SKID state or skid storage synthesised.

Structure
REQ-028 Shared package pipeline_pkg SHALL hold XLEN=32, NOP constant 32'h00000013, PC increment 4, fetch FSM state enum.
REQ-029 IF/ID register SHALL be a sub-module if_id_reg (load, hold, clear inputs); PC register and FSM stay in fetch_stage.

Verification
REQ-030 Reset release, RESET_PC=0, memory 1-cycle latency returning 32'h00A00093 -> imem_req at edge 1 with addr 0; Instruction=32'h00A00093, PC_ID=0, Valid_ID=1; next imem_addr=4.
REQ-031 SignalPC=1 for 3 cycles with IF/ID holding 32'h8A620013 -> Instruction, PC_ID, PC unchanged all 3 cycles; fetch resumes at the same PC after release.
REQ-032 Flush=1, BranchTarget=32'h0000_0100, response pending -> DROP, stale response discarded, Instruction=NOP, Valid_ID=0, next imem_addr=32'h100.
REQ-033 FETCH_SKID_EN, response 32'h00000033 arrives with SignalPC=1 -> IF/ID unchanged; SignalPC drops -> Instruction=32'h00000033 next edge with no new imem_req; without macro -> same address re-requested.
REQ-034 PC=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000 (wrap); rst_n=0 during WAIT -> all outputs at reset values immediately.
